ccg_sweep_misr: RTL and testbench

Exhaustive stimulus sequencer and response compactor for a 6-input / 18-output combinational netlist under test (CUT). It drives all 64 input vectors in ascending order, registers the CUT's 18 output bits on each vector, and folds them into an 18-bit multiple-input signature register (MISR). The resulting signature is compared against a golden value computed offline. The block wraps the CUT directly: `x` feeds the CUT inputs `x0..x5`, and `f` returns the CUT outputs `f1..f18`.

---
 rtl/ccg_sweep_misr.sv | 130 +++++++++++++
 tb/tb_ccg_sweep_misr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_sweep_misr.sv
// ccg_sweep_misr: exhaustive stimulus sequencer and MISR response compactor
// for a small combinational netlist under test (CUT).
//
// Drives every N_IN-bit input vector in ascending order on x, registers the
// CUT response f once per vector, and folds each registered response into an
// N_OUT-bit Galois MISR.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   start      begin a sweep (sampled in IDLE only)
//   hold       freeze all sweep state while high (RUN/DRAIN only)
//   f          CUT response, bit i-1 = CUT output f_i
//   x          CUT stimulus, bit i = CUT input x_i
//   busy       high while the sweep is in RUN or DRAIN
//   done       one-cycle pulse when the signature is final
//   signature  MISR contents, valid whenever busy is low
module ccg_sweep_misr #(
    parameter int unsigned           N_IN  = 6,
    parameter int unsigned           N_OUT = 18,
    parameter logic [N_OUT-1:0]      TAPS  = 18'h00081
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic [N_OUT-1:0]  f,
    output logic [N_IN-1:0]   x,
    output logic              busy,
    output logic              done,
    output logic [N_OUT-1:0]  signature
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [N_IN-1:0] X_LAST = '1;

    logic [1:0]       state,     state_nxt;
    logic [N_IN-1:0]  x_nxt;
    logic [N_OUT-1:0] f_q,       f_q_nxt;
    logic [N_OUT-1:0] sig_nxt;
    logic             first_q,   first_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // One Galois MISR step: shift left, fold the MSB back through TAPS, add d.
    function automatic logic [N_OUT-1:0] misr_step(
        input logic [N_OUT-1:0] s,
        input logic [N_OUT-1:0] d
    );
        return {s[N_OUT-2:0], 1'b0} ^ (s[N_OUT-1] ? TAPS : '0) ^ d;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            x         <= '0;
            f_q       <= '0;
            signature <= '0;
            first_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            f_q       <= f_q_nxt;
            signature <= sig_nxt;
            first_q   <= first_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        f_q_nxt   = f_q;
        sig_nxt   = signature;
        first_nxt = first_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    x_nxt     = '0;
                    f_q_nxt   = '0;
                    sig_nxt   = '0;
                    first_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    f_q_nxt   = f;
                    // f_q is still the cleared value on the first RUN edge.
                    if (!first_q) begin
                        sig_nxt = misr_step(signature, f_q);
                    end
                    first_nxt = 1'b0;
                    if (x == X_LAST) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        x_nxt = x + N_IN'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Absorb the response to the last vector.
                if (!hold) begin
                    sig_nxt   = misr_step(signature, f_q);
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_ccg_sweep_misr.sv
// Self-checking bench for ccg_sweep_misr: table of single-response injection
// sweeps with hand-computed signatures, plus hold, ignored-start, mid-sweep
// reset and a golden sweep over a behavioural CUT.
module tb_ccg_sweep_misr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic [17:0] f;
    logic [5:0]  x;
    logic        busy;
    logic        done;
    logic [17:0] signature;

    int total = 0;
    int bad   = 0;

    logic        use_cut;
    logic [5:0]  inj_x;
    logic [17:0] inj_val;

    ccg_sweep_misr #(.N_IN(6), .N_OUT(18), .TAPS(18'h00081)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .f         (f),
        .x         (x),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the CUT netlist.
    function automatic logic [17:0] cut_f(input logic [5:0] v);
        logic [17:0] w;
        w = 18'(v);
        return 18'(w * w * w) ^ (w << 7) ^ {v, v, v};
    endfunction

    always_comb begin
        if (use_cut) f = cut_f(x);
        else         f = (x == inj_x) ? inj_val : 18'h0;
    end

    function automatic logic [17:0] golden_sig();
        logic [17:0] s;
        s = 18'h0;
        for (int v = 0; v < 64; v++) begin
            s = {s[16:0], 1'b0} ^ (s[17] ? 18'h00081 : 18'h0) ^ cut_f(6'(v));
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one sweep from IDLE. Returns the edge index (start edge = 0) after
    // which done was first seen, the final signature, and the count of
    // sequence errors (x trajectory and frozen signature during hold).
    task automatic run_sweep(input int hold_x, input int hold_len, input int start_x,
                             output int done_edge, output logic [17:0] sig,
                             output int seq_errs);
        int          held;
        int          exp_x;
        logic        was_held;
        logic [17:0] sig_before;
        done_edge = -1;
        seq_errs  = 0;
        held      = 0;
        exp_x     = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (x !== 6'd0 || busy !== 1'b1) seq_errs++;
        for (int e = 1; e < 200; e++) begin
            was_held = 1'b0;
            if (hold_x >= 0 && int'(x) == hold_x && held < hold_len) begin
                hold = 1'b1;
                held++;
                was_held = 1'b1;
            end else begin
                hold = 1'b0;
            end
            start = (start_x >= 0 && int'(x) == start_x) ? 1'b1 : 1'b0;
            sig_before = signature;
            @(posedge clk); #1;
            if (!was_held && exp_x < 63) exp_x++;
            if (was_held && signature !== sig_before) seq_errs++;
            if (!done && int'(x) != exp_x) seq_errs++;
            if (done) begin
                done_edge = e;
                break;
            end
        end
        hold  = 1'b0;
        start = 1'b0;
        sig   = signature;
    endtask

    typedef struct {
        string       name;
        logic [5:0]  ix;
        logic [17:0] iv;
        logic [17:0] exp_sig;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          de;
        int          se;
        logic [17:0] sg;
        logic [17:0] gold;
        logic        idle_ok;

        vecs[0] = '{"zero",      6'd0,  18'h00000, 18'h00000};
        vecs[1] = '{"inj60",     6'd60, 18'h00001, 18'h00008};
        vecs[2] = '{"inj63",     6'd63, 18'h00001, 18'h00001};
        vecs[3] = '{"inj62",     6'd62, 18'h00001, 18'h00002};
        vecs[4] = '{"msb62",     6'd62, 18'h20000, 18'h00081};
        vecs[5] = '{"all63",     6'd63, 18'h3FFFF, 18'h3FFFF};
        vecs[6] = '{"inj50",     6'd50, 18'h00001, 18'h02000};
        vecs[7] = '{"wrap45",    6'd45, 18'h00001, 18'h00081};

        use_cut = 1'b0;
        inj_x   = 6'd0;
        inj_val = 18'h0;
        start   = 1'b0;
        hold    = 1'b0;
        rst_n   = 1'b0;
        gold    = golden_sig();

        // Reset, then stay idle.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_x",    32'(x),         32'h0);
        check("rst_sig",  32'(signature), 32'h0);
        check("rst_busy", 32'(busy),      32'h0);
        check("rst_done", 32'(done),      32'h0);
        idle_ok = 1'b1;
        hold = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (x !== 6'd0 || signature !== 18'h0 || busy !== 1'b0 || done !== 1'b0)
                idle_ok = 1'b0;
        end
        hold = 1'b0;
        check("idle_stable", 32'(idle_ok), 32'h1);

        // Table of injection sweeps.
        for (int i = 0; i < 8; i++) begin
            inj_x   = vecs[i].ix;
            inj_val = vecs[i].iv;
            run_sweep(-1, 0, -1, de, sg, se);
            check({vecs[i].name, "_sig"},  32'(sg), 32'(vecs[i].exp_sig));
            check({vecs[i].name, "_done"}, 32'(de), 32'd65);
            check({vecs[i].name, "_seq"},  32'(se), 32'd0);
            check({vecs[i].name, "_busy"}, 32'(busy), 32'h0);
            // start during DONE must not be sampled.
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({vecs[i].name, "_post_done"}, 32'(done), 32'h0);
            check({vecs[i].name, "_post_busy"}, 32'(busy), 32'h0);
            @(posedge clk); #1;
        end

        // Golden sweep, plain and with a 5-cycle hold at x=20.
        use_cut = 1'b1;
        run_sweep(-1, 0, -1, de, sg, se);
        check("golden_sig",  32'(sg), 32'(gold));
        check("golden_done", 32'(de), 32'd65);
        repeat (2) @(posedge clk);
        #1;
        run_sweep(20, 5, -1, de, sg, se);
        check("hold_sig",  32'(sg), 32'(gold));
        check("hold_done", 32'(de), 32'd70);
        check("hold_seq",  32'(se), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Start pulsed mid-sweep is ignored.
        run_sweep(-1, 0, 30, de, sg, se);
        check("ign_start_sig",  32'(sg), 32'(gold));
        check("ign_start_done", 32'(de), 32'd65);
        check("ign_start_seq",  32'(se), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Mid-sweep reset at x=40.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < 100 && x != 6'd40; e++) begin
            @(posedge clk); #1;
        end
        check("mid_reached40", 32'(x), 32'd40);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_x",    32'(x),         32'h0);
        check("mid_rst_sig",  32'(signature), 32'h0);
        check("mid_rst_busy", 32'(busy),      32'h0);
        idle_ok = 1'b1;
        repeat (70) begin
            if (done !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
            @(posedge clk); #1;
        end
        check("mid_no_done", 32'(idle_ok), 32'h1);
        run_sweep(-1, 0, -1, de, sg, se);
        check("mid_fresh_sig",  32'(sg), 32'(gold));
        check("mid_fresh_done", 32'(de), 32'd65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
